fibo_seq_gen: RTL

- Parametrised successor to the team's fixed-width Fibonacci engine.
- Computes the i-th term of a two-term additive recurrence: Fibonacci, Lucas, or user seeds (optional feature).
- Iterative single adder; start/busy/finish handshake; sticky overflow flag.
- Sits behind a control FSM or testbench driver as a multi-cycle arithmetic slave.

---
 rtl/fibo_pkg.sv | 28 ++
 rtl/fibo_step.sv | 25 ++
 rtl/fibo_seq_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fibo_pkg.sv
`default_nettype none
// ============================================================
// fibo_pkg : state encoding, mode and seed constants for fibo_seq_gen
// Revision : 1.0
// ============================================================
package fibo_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CALC = 1'b1;

   localparam logic MODE_FIB = 1'b0;
   localparam logic MODE_LUC = 1'b1;

   localparam int unsigned FIB_S0 = 0;
   localparam int unsigned FIB_S1 = 1;
   localparam int unsigned LUC_S0 = 2;
   localparam int unsigned LUC_S1 = 1;

   function automatic int unsigned seed0_of(input logic mode);
      return (mode == MODE_LUC) ? LUC_S0 : FIB_S0;
   endfunction

   function automatic int unsigned seed1_of(input logic mode);
      return (mode == MODE_LUC) ? LUC_S1 : FIB_S1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fibo_step.sv
`default_nettype none
// ============================================================
// fibo_step : one recurrence step (a,b) -> (b, a+b) with carry out
// Revision  : 1.0
// ============================================================
module fibo_step #(
   parameter int RES_W = 20
) (
   input  logic [RES_W-1:0] a_i,
   input  logic [RES_W-1:0] b_i,
   output logic [RES_W-1:0] a_o,
   output logic [RES_W-1:0] b_o,
   output logic             carry_o
);
   import fibo_pkg::*;

   logic [RES_W:0] w_sum;

   assign w_sum   = {1'b0, a_i} + {1'b0, b_i};
   assign a_o     = b_i;
   assign b_o     = w_sum[RES_W-1:0];
   assign carry_o = w_sum[RES_W];

endmodule
`default_nettype wire

// File: rtl/fibo_seq_gen.sv
`default_nettype none
// ============================================================
// fibo_seq_gen : iterative i-th term of a Fibonacci/Lucas recurrence
//                optional custom seeds via FIBO_CUSTOM_SEED_EN
// Revision     : 1.0
// ============================================================
module fibo_seq_gen #(
   parameter int IDX_W = 5,
   parameter int RES_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] i,
   input  logic             mode,
`ifdef FIBO_CUSTOM_SEED_EN
   input  logic             use_seed,
   input  logic [RES_W-1:0] seed0,
   input  logic [RES_W-1:0] seed1,
`endif
   output logic             busy,
   output logic             finish,
   output logic [RES_W-1:0] result,
   output logic             overflow
);
   import fibo_pkg::*;

   logic [0:0]       state_q, state_d;
   logic [RES_W-1:0] a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [RES_W-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             finish_q, finish_d;

   logic [RES_W-1:0] w_next_a, w_next_b;
   logic             w_carry;
   logic [RES_W-1:0] w_seed0, w_seed1;

   fibo_step #(.RES_W(RES_W)) u_step (
      .a_i     (a_q),
      .b_i     (b_q),
      .a_o     (w_next_a),
      .b_o     (w_next_b),
      .carry_o (w_carry)
   );

`ifdef FIBO_CUSTOM_SEED_EN
   assign w_seed0 = use_seed ? seed0 : RES_W'(seed0_of(mode));
   assign w_seed1 = use_seed ? seed1 : RES_W'(seed1_of(mode));
`else
   assign w_seed0 = RES_W'(seed0_of(mode));
   assign w_seed1 = RES_W'(seed1_of(mode));
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         finish_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         finish_q  <= finish_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      finish_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CALC;
               a_d       = w_seed0;
               b_d       = w_seed1;
               cnt_d     = i;
               ovf_acc_d = 1'b0;
            end
         end
         ST_CALC: begin
            if (cnt_q != '0) begin
               a_d       = w_next_a;
               b_d       = w_next_b;
               cnt_d     = cnt_q - IDX_W'(1);
               // the last step only refreshes b, which is never reported
               ovf_acc_d = ovf_acc_q | (w_carry & (cnt_q > IDX_W'(1)));
            end else begin
               result_d = a_q;
               ovf_d    = ovf_acc_q;
               finish_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == ST_CALC);
      finish   = finish_q;
      result   = result_q;
      overflow = ovf_q;
   end

endmodule
`default_nettype wire
